// File: rtl/tone_step_sequencer_pkg.sv
// rtl/tone_step_sequencer_pkg.sv - shared types and level constants for the tone step sequencer
//
// Package tone_seq_pkg: sequencer FSM state encoding and the standard wavegen amplitude
// levels used when programming step tables.

package tone_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        PLAY   = 2'd2,
        RAMPDN = 2'd3
    } seq_state_t;

    // Full-scale wavegen amplitude and common attenuated settings (unsigned, 40 bits).
    localparam logic [39:0] LEVEL_0DB   = 40'd1304065748 * 40'd256;
    localparam logic [39:0] LEVEL_N12DB = 40'd1304065748 * 40'd64;
    localparam logic [39:0] LEVEL_N60DB = 40'd1304065748 / 40'd4;
    localparam logic [39:0] LEVEL_MUTE  = 40'd0;

endpackage

// File: rtl/tone_step_sequencer_if.sv
// rtl/tone_step_sequencer_if.sv - step table configuration bus
//
// Signals:
//   cfg_we     step table write strobe
//   cfg_addr   table index
//   cfg_angle  step phase increment
//   cfg_level  step amplitude (unsigned)
//   cfg_dwell  samples to hold the step; 0 marks end-of-list
// Modports: master drives the bus (register side), slave receives it (sequencer).

interface tone_step_sequencer_if #(
    parameter int N_STEPS = 8,
    parameter int ANGLE_W = 32,
    parameter int LEVEL_W = 40,
    parameter int DWELL_W = 16
);
    localparam int IDX_W = $clog2(N_STEPS);

    logic               cfg_we;
    logic [IDX_W-1:0]   cfg_addr;
    logic [ANGLE_W-1:0] cfg_angle;
    logic [LEVEL_W-1:0] cfg_level;
    logic [DWELL_W-1:0] cfg_dwell;

    modport master (output cfg_we, cfg_addr, cfg_angle, cfg_level, cfg_dwell);
    modport slave  (input  cfg_we, cfg_addr, cfg_angle, cfg_level, cfg_dwell);

endinterface

// File: rtl/tone_step_sequencer_table.sv
// rtl/tone_step_sequencer_table.sv - step table register file
//
// Module tone_step_table: N_STEPS entries of {angle, level, dwell}.
// Ports:
//   mclk                              clock
//   wr_en / wr_addr / wr_*            single synchronous write port
//   rd_addr / rd_angle/level/dwell    single asynchronous read port
// Contents are not reset; entries must be written before they are played.

module tone_step_table #(
    parameter int N_STEPS = 8,
    parameter int ANGLE_W = 32,
    parameter int LEVEL_W = 40,
    parameter int DWELL_W = 16
) (
    input  logic                       mclk,
    input  logic                       wr_en,
    input  logic [$clog2(N_STEPS)-1:0] wr_addr,
    input  logic [ANGLE_W-1:0]         wr_angle,
    input  logic [LEVEL_W-1:0]         wr_level,
    input  logic [DWELL_W-1:0]         wr_dwell,
    input  logic [$clog2(N_STEPS)-1:0] rd_addr,
    output logic [ANGLE_W-1:0]         rd_angle,
    output logic [LEVEL_W-1:0]         rd_level,
    output logic [DWELL_W-1:0]         rd_dwell
);
    localparam int ENTRY_W = ANGLE_W + LEVEL_W + DWELL_W;

    logic [ENTRY_W-1:0] mem [N_STEPS];

    always_ff @(posedge mclk) begin
        if (wr_en) begin
            mem[wr_addr] <= {wr_angle, wr_level, wr_dwell};
        end
    end

    assign {rd_angle, rd_level, rd_dwell} = mem[rd_addr];

endmodule

// File: rtl/tone_step_sequencer.sv
// rtl/tone_step_sequencer.sv - steps the sine wavegen through a programmable (angle, level, dwell) list
//
// Ports:
//   mclk, reset_n        master clock, asynchronous active-low reset
//   cfg                  step table write bus (tone_step_sequencer_if.slave)
//   start / stop         pulses: begin at step 0 / abort (stop wins over start)
//   loop_en              wrap to step 0 at end-of-list instead of finishing
//   sample_stb           1-cycle pulse every SAMPLE_DIV mclk cycles
//   wg_start/angle/level wavegen enable, phase increment, amplitude
//   busy, step_idx, done sequence active, current step, end/abort pulse
// Optional feature: define LEVEL_RAMP_EN to slew wg_level toward the step target by
// (target-cur)>>>RAMP_SHIFT per sample; otherwise the level jumps on the next sample.

module tone_step_sequencer
    import tone_seq_pkg::*;
#(
    parameter int N_STEPS    = 8,
    parameter int SAMPLE_DIV = 512,
    parameter int ANGLE_W    = 32,
    parameter int LEVEL_W    = 40,
    parameter int DWELL_W    = 16,
    parameter int RAMP_SHIFT = 4
) (
    input  logic                       mclk,
    input  logic                       reset_n,
    tone_step_sequencer_if.slave       cfg,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       loop_en,
    output logic                       sample_stb,
    output logic                       wg_start,
    output logic [ANGLE_W-1:0]         wg_angle,
    output logic [LEVEL_W-1:0]         wg_level,
    output logic                       busy,
    output logic [$clog2(N_STEPS)-1:0] step_idx,
    output logic                       done
);
    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic signed [LEVEL_W:0] RAMP_UNIT = (LEVEL_W + 1)'(1) << RAMP_SHIFT;
`ifdef LEVEL_RAMP_EN
    localparam bit RAMP_EN = 1'b1;
`else
    localparam bit RAMP_EN = 1'b0;
`endif

    seq_state_t         state;
    logic [DIV_W-1:0]   div_cnt;
    logic [LEVEL_W-1:0] target;
    logic [DWELL_W-1:0] dwell_cnt;

    logic [ANGLE_W-1:0] rd_angle;
    logic [LEVEL_W-1:0] rd_level;
    logic [DWELL_W-1:0] rd_dwell;

    tone_step_table #(
        .N_STEPS (N_STEPS),
        .ANGLE_W (ANGLE_W),
        .LEVEL_W (LEVEL_W),
        .DWELL_W (DWELL_W)
    ) u_table (
        .mclk     (mclk),
        .wr_en    (cfg.cfg_we),
        .wr_addr  (cfg.cfg_addr),
        .wr_angle (cfg.cfg_angle),
        .wr_level (cfg.cfg_level),
        .wr_dwell (cfg.cfg_dwell),
        .rd_addr  (step_idx),
        .rd_angle (rd_angle),
        .rd_level (rd_level),
        .rd_dwell (rd_dwell)
    );

    // Free-running sample divider; it keeps counting whatever the sequencer does.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign sample_stb = (div_cnt == DIV_LAST);

    // Level slew. The step is a fraction of the remaining distance, so it can never
    // carry the level past the target; small distances snap straight onto it.
    logic signed [LEVEL_W:0] lvl_diff;
    logic signed [LEVEL_W:0] lvl_step;
    logic signed [LEVEL_W:0] lvl_sum;
    logic                    lvl_small;
    logic [LEVEL_W-1:0]      lvl_next;

    always_comb begin
        lvl_diff  = $signed({1'b0, target}) - $signed({1'b0, wg_level});
        lvl_step  = lvl_diff >>> RAMP_SHIFT;
        lvl_sum   = $signed({1'b0, wg_level}) + lvl_step;
        lvl_small = (lvl_diff < RAMP_UNIT) && (lvl_diff > -RAMP_UNIT);
        lvl_next  = target;
        if (RAMP_EN && !lvl_small && !lvl_sum[LEVEL_W]) begin
            lvl_next = lvl_sum[LEVEL_W-1:0];
        end
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            step_idx  <= '0;
            wg_angle  <= '0;
            wg_level  <= '0;
            target    <= '0;
            dwell_cnt <= '0;
            wg_start  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state    <= LOAD;
                        step_idx <= '0;
                        busy     <= 1'b1;
                        wg_start <= 1'b1;
                    end
                end
                LOAD: begin
                    if (stop) begin
                        target <= '0;
                        state  <= RAMPDN;
                    end else if (rd_dwell == '0) begin
                        // End-of-list. Looping from an empty step 0 would spin forever,
                        // so that case finishes instead.
                        if (loop_en && step_idx != '0) begin
                            step_idx <= '0;
                        end else begin
                            target <= '0;
                            state  <= RAMPDN;
                        end
                    end else begin
                        wg_angle  <= rd_angle;
                        target    <= rd_level;
                        dwell_cnt <= rd_dwell;
                        state     <= PLAY;
                    end
                end
                PLAY: begin
                    if (sample_stb) begin
                        wg_level <= lvl_next;
                    end
                    if (stop) begin
                        target <= '0;
                        state  <= RAMPDN;
                    end else if (sample_stb) begin
                        dwell_cnt <= dwell_cnt - 1'b1;
                        if (dwell_cnt == DWELL_W'(1)) begin
                            step_idx <= step_idx + 1'b1;
                            state    <= LOAD;
                        end
                    end
                end
                RAMPDN: begin
                    if (wg_level == '0) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        wg_start <= 1'b0;
                        done     <= 1'b1;
                    end else if (sample_stb) begin
                        wg_level <= lvl_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tone_step_sequencer.sv
// tb/tb_tone_step_sequencer.sv - self-checking bench for tone_step_sequencer

module tb_tone_step_sequencer;

    localparam int N_STEPS = 8;
    localparam int ANGLE_W = 32;
    localparam int LEVEL_W = 40;
    localparam int DWELL_W = 16;
`ifdef LEVEL_RAMP_EN
    localparam int SDIV = 16;
`else
    localparam int SDIV = 512;
`endif

    localparam logic [31:0] A0  = 32'd12173944;
    localparam logic [31:0] A1  = 32'd3043486;
    localparam logic [39:0] L0  = 40'd333840831488;
    localparam logic [39:0] L12 = 40'd83460207872;

    logic        mclk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic        sample_stb;
    logic        wg_start;
    logic [31:0] wg_angle;
    logic [39:0] wg_level;
    logic        busy;
    logic [2:0]  step_idx;
    logic        done;

    int n_checks = 0;
    int n_fail = 0;

    tone_step_sequencer_if #(
        .N_STEPS(N_STEPS), .ANGLE_W(ANGLE_W), .LEVEL_W(LEVEL_W), .DWELL_W(DWELL_W)
    ) cfg_bus ();

    tone_step_sequencer #(
        .N_STEPS(N_STEPS), .SAMPLE_DIV(SDIV), .ANGLE_W(ANGLE_W),
        .LEVEL_W(LEVEL_W), .DWELL_W(DWELL_W), .RAMP_SHIFT(4)
    ) dut (
        .mclk       (mclk),
        .reset_n    (reset_n),
        .cfg        (cfg_bus),
        .start      (start),
        .stop       (stop),
        .loop_en    (loop_en),
        .sample_stb (sample_stb),
        .wg_start   (wg_start),
        .wg_angle   (wg_angle),
        .wg_level   (wg_level),
        .busy       (busy),
        .step_idx   (step_idx),
        .done       (done)
    );

    always #5 mclk = ~mclk;

    typedef struct packed {
        logic        start;
        logic        loop_en;
        logic [31:0] angle;
        logic [39:0] level;
        logic [2:0]  idx;
        logic        busy;
        logic        done;
        logic        wg_start;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic write_step(input logic [2:0] a, input logic [31:0] ang,
                              input logic [39:0] lvl, input logic [15:0] dw);
        cfg_bus.cfg_we    = 1'b1;
        cfg_bus.cfg_addr  = a;
        cfg_bus.cfg_angle = ang;
        cfg_bus.cfg_level = lvl;
        cfg_bus.cfg_dwell = dw;
        @(negedge mclk);
        cfg_bus.cfg_we = 1'b0;
    endtask

    // Returns at the negedge just after the posedge on which sample_stb was high.
    task automatic wait_stb();
        int n = 0;
        while (sample_stb !== 1'b1 && n < 2 * SDIV) begin
            @(negedge mclk);
            n++;
        end
        if (n >= 2 * SDIV) begin
            check("stb_timeout", 64'(sample_stb), 64'd1);
        end
        @(negedge mclk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge mclk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit seen);
        int n = 0;
        seen = 1'b0;
        while (!seen && n < limit) begin
            @(negedge mclk);
            n++;
            if (done === 1'b1) seen = 1'b1;
        end
    endtask

    initial begin
        int  k;
        bit  seen;
        vecs[0]  = '{1'b1, 1'b0, A0, L0,    3'd0, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, A0, L0,    3'd0, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, A1, L0,    3'd1, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, A1, L12,   3'd1, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, A1, L12,   3'd2, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, A1, 40'd0, 3'd2, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, A0, L0,    3'd0, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, A0, L0,    3'd0, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, A1, L0,    3'd1, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, A1, L12,   3'd1, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, A1, L12,   3'd0, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, A0, L0,    3'd0, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b1, A0, L0,    3'd0, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b1, A1, L0,    3'd1, 1'b1, 1'b0, 1'b1};

        cfg_bus.cfg_we    = 1'b0;
        cfg_bus.cfg_addr  = '0;
        cfg_bus.cfg_angle = '0;
        cfg_bus.cfg_level = '0;
        cfg_bus.cfg_dwell = '0;

        // Reset state
        #1;
        check("rst_wg_start", 64'(wg_start), 64'd0);
        check("rst_wg_level", 64'(wg_level), 64'd0);
        check("rst_wg_angle", 64'(wg_angle), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_stb", 64'(sample_stb), 64'd0);
        repeat (3) @(negedge mclk);
        reset_n = 1'b1;

        // Idle divider period
        wait_stb();
        k = 0;
        while (sample_stb !== 1'b1 && k < 2 * SDIV) begin
            @(negedge mclk);
            k++;
        end
        check("stb_period", 64'(k + 1), 64'(SDIV));
        @(negedge mclk);
        check("stb_width", 64'(sample_stb), 64'd0);
        check("idle_wg_start", 64'(wg_start), 64'd0);
        check("idle_wg_level", 64'(wg_level), 64'd0);

        write_step(3'd0, A0, L0, 16'd3);
        write_step(3'd1, A1, L12, 16'd2);
        write_step(3'd2, 32'd0, 40'd0, 16'd0);

`ifndef LEVEL_RAMP_EN
        // Two-step list, then the same list looping
        wait_stb();
        for (int i = 0; i < 14; i++) begin
            loop_en = vecs[i].loop_en;
            if (vecs[i].start) pulse_start();
            wait_stb();
            @(negedge mclk);
            check($sformatf("v%0d_angle", i), 64'(wg_angle), 64'(vecs[i].angle));
            check($sformatf("v%0d_level", i), 64'(wg_level), 64'(vecs[i].level));
            check($sformatf("v%0d_idx", i), 64'(step_idx), 64'(vecs[i].idx));
            check($sformatf("v%0d_busy", i), 64'(busy), 64'(vecs[i].busy));
            check($sformatf("v%0d_done", i), 64'(done), 64'(vecs[i].done));
            check($sformatf("v%0d_wg_start", i), 64'(wg_start), 64'(vecs[i].wg_start));
        end

        // Stop during step 1 with start in the same cycle: stop wins
        start = 1'b1;
        stop  = 1'b1;
        @(negedge mclk);
        start = 1'b0;
        stop  = 1'b0;
        check("stop_busy", 64'(busy), 64'd1);
        check("stop_done_early", 64'(done), 64'd0);
        wait_stb();
        @(negedge mclk);
        check("stop_done", 64'(done), 64'd1);
        check("stop_busy_fall", 64'(busy), 64'd0);
        check("stop_level", 64'(wg_level), 64'd0);
        check("stop_wg_start", 64'(wg_start), 64'd0);
        @(negedge mclk);
        check("stop_done_pulse", 64'(done), 64'd0);
        check("stop_start_ignored", 64'(busy), 64'd0);
        stop = 1'b1;
        @(negedge mclk);
        stop = 1'b0;
        @(negedge mclk);
        check("idle_stop_busy", 64'(busy), 64'd0);
        check("idle_stop_done", 64'(done), 64'd0);
        loop_en = 1'b0;

        // Asynchronous reset mid-PLAY, then replay from step 0
        wait_stb();
        pulse_start();
        wait_stb();
        @(negedge mclk);
        check("pre_rst_level", 64'(wg_level), 64'(L0));
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_wg_start", 64'(wg_start), 64'd0);
        check("arst_wg_angle", 64'(wg_angle), 64'd0);
        check("arst_wg_level", 64'(wg_level), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_idx", 64'(step_idx), 64'd0);
        @(negedge mclk);
        reset_n = 1'b1;
        wait_stb();
        pulse_start();
        wait_stb();
        @(negedge mclk);
        check("replay_angle", 64'(wg_angle), 64'(A0));
        check("replay_level", 64'(wg_level), 64'(L0));
        check("replay_idx", 64'(step_idx), 64'd0);
        stop = 1'b1;
        @(negedge mclk);
        stop = 1'b0;
        wait_done(3 * SDIV, seen);
        check("replay_stop_done", 64'(seen), 64'd1);

        // Empty step 0 with loop_en: must finish rather than loop
        write_step(3'd0, A0, L0, 16'd0);
        loop_en = 1'b1;
        pulse_start();
        wait_done(10, seen);
        check("empty_list_done", 64'(seen), 64'd1);
        check("empty_list_level", 64'(wg_level), 64'd0);
        check("empty_list_idx", 64'(step_idx), 64'd0);
        loop_en = 1'b0;
`else
        // Level ramp from 0 to full scale
        begin
            logic        [39:0] prev;
            logic signed [40:0] d;
            logic signed [40:0] m;
            write_step(3'd0, A0, L0, 16'd1000);
            wait_stb();
            pulse_start();
            wait_stb();
            @(negedge mclk);
            check("ramp_first", 64'(wg_level), 64'(L0 >> 4));
            for (int j = 0; j < 600 && wg_level !== L0; j++) begin
                prev = wg_level;
                d = $signed({1'b0, L0}) - $signed({1'b0, prev});
                if (d < 41'sd16 && d > -41'sd16) m = $signed({1'b0, L0});
                else m = $signed({1'b0, prev}) + (d >>> 4);
                wait_stb();
                @(negedge mclk);
                check("ramp_step", 64'(wg_level), 64'(m[39:0]));
                check("ramp_monotonic", 64'(wg_level >= prev && wg_level <= L0), 64'd1);
            end
            check("ramp_final", 64'(wg_level), 64'(L0));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
